// File: rtl/dsd_pkg.sv
// Shared types and sizing for the truth-table sweeper and its hold timer.
// Every sweep covers all 16 input vectors of a 4-input block.
package dsd_pkg;

  localparam int unsigned N_VEC  = 16;
  localparam int unsigned VEC_W  = 4;
  localparam int unsigned CNT_W  = $clog2(N_VEC + 1);
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [VEC_W-1:0] vec_t;
  typedef logic [N_VEC-1:0] tt_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, vector-drive and result signals between the sweeper and its environment.
// The slave side is the sweeper; the master side is the host plus the block under test.
interface truth_table_sweeper_if;
  import dsd_pkg::*;

  logic start;
  logic a;
  logic b;
  logic c;
  logic d;
  logic f;
  logic busy;
  logic done;
  tt_t  tt;
  cnt_t mismatch_cnt;
  vec_t first_fail_idx;
  logic fail;

  modport master (
    output start,
    output f,
    input  a,
    input  b,
    input  c,
    input  d,
    input  busy,
    input  done,
    input  tt,
    input  mismatch_cnt,
    input  first_fail_idx,
    input  fail
  );

  modport slave (
    input  start,
    input  f,
    output a,
    output b,
    output c,
    output d,
    output busy,
    output done,
    output tt,
    output mismatch_cnt,
    output first_fail_idx,
    output fail
  );

endinterface

// File: rtl/sweep_hold_timer.sv
// Down-counter that pulses tick for one cycle every HOLD_CYCLES enabled cycles.
// clear reloads the count so the next vector gets a full hold window.
module sweep_hold_timer
  import dsd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [HOLD_W-1:0] Reload = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = Reload;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? Reload : cnt_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 vectors into a 4-input combinational block, captures f into a truth
// table and compares it against EXP_TT, reporting mismatch count and first failing index.
module truth_table_sweeper
  import dsd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter tt_t         EXP_TT      = 16'h0000
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);

  state_e state_q, state_d;
  vec_t   idx_q, idx_d;
  tt_t    tt_q, tt_d;
  cnt_t   mis_q, mis_d;
  vec_t   ffi_q, ffi_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   timer_clear;
  logic   timer_en;
  logic   tick;

  assign timer_en = (state_q == ST_DRIVE);

  sweep_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(timer_clear),
    .en   (timer_en),
    .tick (tick)
  );

  // busy/done are registered off the current state, so both lag the state by one edge.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tt_d        = tt_q;
    mis_d       = mis_q;
    ffi_d       = ffi_q;
    timer_clear = 1'b0;
    busy_d      = (state_q == ST_DRIVE);
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_d = (state_q == ST_DONE);
        if (bus.start) begin
          state_d     = ST_DRIVE;
          idx_d       = '0;
          tt_d        = '0;
          mis_d       = '0;
          ffi_d       = '0;
          timer_clear = 1'b1;
          done_d      = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (tick) begin
          tt_d[idx_q] = bus.f;
          if (bus.f != EXP_TT[idx_q]) begin
            mis_d = mis_q + cnt_t'(1);
            if (mis_q == '0) begin
              ffi_d = idx_q;
            end
          end
          // The last vector stays on a..d; idx never wraps into a second sweep.
          if (idx_q == vec_t'(N_VEC - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + vec_t'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tt_q    <= '0;
      mis_q   <= '0;
      ffi_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      mis_q   <= mis_d;
      ffi_q   <= ffi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a              = idx_q[3];
  assign bus.b              = idx_q[2];
  assign bus.c              = idx_q[1];
  assign bus.d              = idx_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.tt             = tt_q;
  assign bus.mismatch_cnt   = mis_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.fail           = (mis_q != '0);

  busy_done_exclusive: assert property (@(posedge clk) !(busy_q && done_q));

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: dut0 sweeps a parity/zero block against 16'h6996 with 4-cycle holds,
// dut1 sweeps a&b against 16'hF000 with single-cycle holds.
module tb_truth_table_sweeper;
  import dsd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_xor;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_sweeper_if bus0 ();
  truth_table_sweeper_if bus1 ();

  assign bus0.f = f_xor ? (bus0.a ^ bus0.b ^ bus0.c ^ bus0.d) : 1'b0;
  assign bus1.f = bus1.a & bus1.b;

  truth_table_sweeper #(
    .HOLD_CYCLES(4),
    .EXP_TT     (16'h6996)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  truth_table_sweeper #(
    .HOLD_CYCLES(1),
    .EXP_TT     (16'hF000)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start for one edge; returns the cycle count of the start edge.
  task automatic pulse_start(input bit which, output int unsigned kk);
    @(negedge clk);
    if (which) bus1.start = 1'b1;
    else       bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    kk = cyc;
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_vec0(input string tag, input logic [3:0] v);
    int unsigned n = 0;
    while ({bus0.a, bus0.b, bus0.c, bus0.d} != v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {bus0.a, bus0.b, bus0.c, bus0.d}, v);
  endtask

  task automatic check_cleared0(input string tag);
    check({tag, "_tt"},   bus0.tt, 16'h0000);
    check({tag, "_mis"},  bus0.mismatch_cnt, 0);
    check({tag, "_ffi"},  bus0.first_fail_idx, 0);
    check({tag, "_fail"}, bus0.fail, 0);
    check({tag, "_busy"}, bus0.busy, 0);
    check({tag, "_done"}, bus0.done, 0);
    check({tag, "_vec"},  {bus0.a, bus0.b, bus0.c, bus0.d}, 4'h0);
  endtask

  // done must still be low after edge kk+n-1 and high after edge kk+n.
  task automatic check_done_at0(input string tag, input int unsigned kk, input int unsigned n);
    wait_cyc(kk + n - 1);
    check({tag, "_done_early"}, bus0.done, 0);
    check({tag, "_busy_last"},  bus0.busy, 1);
    wait_cyc(kk + n);
    check({tag, "_done"},       bus0.done, 1);
    check({tag, "_busy_end"},   bus0.busy, 0);
    check({tag, "_vec_end"},    {bus0.a, bus0.b, bus0.c, bus0.d}, 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    f_xor      = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared0("reset");
    check("reset_dut1_done", bus1.done, 0);
    rst_n = 1'b1;

    // 1: parity block matches golden table
    pulse_start(1'b0, k);
    wait_cyc(k + 1);
    check("t1_busy_rise", bus0.busy, 1);
    wait_cyc(k + 3);
    check("t1_vec0_held", {bus0.a, bus0.b, bus0.c, bus0.d}, 4'h0);
    wait_cyc(k + 4);
    check("t1_vec1", {bus0.a, bus0.b, bus0.c, bus0.d}, 4'h1);
    check_done_at0("t1", k, 65);
    check("t1_tt", bus0.tt, 16'h6996);
    check("t1_mis", bus0.mismatch_cnt, 0);
    check("t1_fail", bus0.fail, 0);

    // 2: f stuck at 0
    f_xor = 1'b0;
    pulse_start(1'b0, k);
    check_done_at0("t2", k, 65);
    check("t2_tt", bus0.tt, 16'h0000);
    check("t2_mis", bus0.mismatch_cnt, 8);
    check("t2_ffi", bus0.first_fail_idx, 1);
    check("t2_fail", bus0.fail, 1);

    // 6: restart from a failing DONE clears results at the start edge
    f_xor = 1'b1;
    pulse_start(1'b0, k);
    check("t6_tt_clr", bus0.tt, 16'h0000);
    check("t6_mis_clr", bus0.mismatch_cnt, 0);
    check("t6_fail_clr", bus0.fail, 0);
    check("t6_done_clr", bus0.done, 0);
    check_done_at0("t6", k, 65);
    check("t6_tt", bus0.tt, 16'h6996);
    check("t6_mis", bus0.mismatch_cnt, 0);
    check("t6_fail", bus0.fail, 0);

    // 3: reset mid-sweep at idx 7
    pulse_start(1'b0, k);
    wait_vec0("t3_reach7", 4'h7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared0("t3_rst");
    repeat (3) @(negedge clk);
    check("t3_idle_busy", bus0.busy, 0);
    check("t3_idle_vec", {bus0.a, bus0.b, bus0.c, bus0.d}, 4'h0);
    pulse_start(1'b0, k);
    check_done_at0("t3", k, 65);
    check("t3_tt", bus0.tt, 16'h6996);
    check("t3_mis", bus0.mismatch_cnt, 0);

    // 4: start while busy is ignored
    pulse_start(1'b0, k);
    wait_vec0("t4_reach3", 4'h3);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    check("t4_busy", bus0.busy, 1);
    check("t4_vec_kept", {bus0.a, bus0.b, bus0.c, bus0.d}, 4'h3);
    check_done_at0("t4", k, 65);
    check("t4_tt", bus0.tt, 16'h6996);
    check("t4_fail", bus0.fail, 0);

    // 5: single-cycle hold, f = a&b
    pulse_start(1'b1, k);
    check("t5_vec0", {bus1.a, bus1.b, bus1.c, bus1.d}, 4'h0);
    wait_cyc(k + 1);
    check("t5_vec1", {bus1.a, bus1.b, bus1.c, bus1.d}, 4'h1);
    check("t5_busy", bus1.busy, 1);
    wait_cyc(k + 2);
    check("t5_vec2", {bus1.a, bus1.b, bus1.c, bus1.d}, 4'h2);
    wait_cyc(k + 16);
    check("t5_done_early", bus1.done, 0);
    wait_cyc(k + 17);
    check("t5_done", bus1.done, 1);
    check("t5_tt", bus1.tt, 16'hF000);
    check("t5_mis", bus1.mismatch_cnt, 0);
    check("t5_fail", bus1.fail, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
